reg_file_hs: RTL and testbench

Sixteen-entry, 16-bit general-purpose register file with a request/acknowledge write port driven by the writeback stage, two combinational read ports for the operand-fetch stage, and a per-register pending scoreboard. It sits directly downstream of writeback, terminating its `write_en`/`reg_ack` handshake. It also tells decode whether a source register still has a result in flight. Register 0 reads as zero and is never written.

---
 rtl/reg_file_hs.sv | 58 +++++
 tb/tb_reg_file_hs.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_hs.sv
// reg_file_hs: 16x16 register file with req/ack write port, two read ports and pending scoreboard
module reg_file_hs #(
    parameter int NREGS = 16,
    parameter int AW = 4,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          write_en,
    input  logic [AW-1:0] write_addr,
    input  logic [DW-1:0] write_data,
    output logic          reg_ack,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [DW-1:0] rd_data_a,
    output logic [DW-1:0] rd_data_b,
    output logic          busy_a,
    output logic          busy_b,
    input  logic          reserve_en,
    input  logic [AW-1:0] reserve_addr
);
    typedef enum logic [1:0] {IDLE, ACK, WAIT_LOW} state_t;
    state_t state_q, state_d;
    logic [DW-1:0] regs_q [NREGS];
    logic [DW-1:0] regs_d [NREGS];
    logic [NREGS-1:0] pending_q, pending_d;
    logic ack_q, ack_d;
    logic commit;
    always_comb begin
        commit = (state_q == IDLE) && write_en;
        state_d = (state_q == IDLE) ? (write_en ? ACK : IDLE) : (write_en ? WAIT_LOW : IDLE);
        ack_d = commit;
        regs_d = regs_q;
        if (commit && write_addr != '0) regs_d[write_addr] = write_data;
        pending_d = pending_q;
        if (commit) pending_d[write_addr] = 1'b0;
        if (reserve_en) pending_d[reserve_addr] = 1'b1;
        pending_d[0] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            regs_q <= '{default: '0};
            pending_q <= '0;
            ack_q <= 1'b0;
        end else begin
            state_q <= state_d;
            regs_q <= regs_d;
            pending_q <= pending_d;
            ack_q <= ack_d;
        end
    end
    assign reg_ack = ack_q;
    assign rd_data_a = (rd_addr_a == '0) ? '0 : regs_q[rd_addr_a];
    assign rd_data_b = (rd_addr_b == '0) ? '0 : regs_q[rd_addr_b];
    assign busy_a = pending_q[rd_addr_a];
    assign busy_b = pending_q[rd_addr_b];
endmodule

// File: tb/tb_reg_file_hs.sv
// tb_reg_file_hs: directed self-checking bench for reg_file_hs
module tb_reg_file_hs;
    logic clk = 1'b0;
    logic rst_n, write_en, reg_ack, busy_a, busy_b, reserve_en;
    logic [3:0] write_addr, rd_addr_a, rd_addr_b, reserve_addr;
    logic [15:0] write_data, rd_data_a, rd_data_b;
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int acks, c1, c2, c3;
    reg_file_hs dut (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .write_addr(write_addr),
        .write_data(write_data), .reg_ack(reg_ack), .rd_addr_a(rd_addr_a),
        .rd_addr_b(rd_addr_b), .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
        .busy_a(busy_a), .busy_b(busy_b), .reserve_en(reserve_en), .reserve_addr(reserve_addr)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic wb_write(input logic [3:0] a, input logic [15:0] d, output int ack_cyc);
        write_en = 1'b1;
        write_addr = a;
        write_data = d;
        ack_cyc = -1;
        for (int n = 0; n < 8 && ack_cyc < 0; n++) begin
            step();
            if (reg_ack) ack_cyc = cyc;
        end
        chk("wb_ack_seen", 32'(ack_cyc >= 0), 1);
        step();
        write_en = 1'b0;
        step();
    endtask
    initial begin
        rst_n = 1'b0; write_en = 1'b0; write_addr = '0; write_data = '0;
        rd_addr_a = '0; rd_addr_b = '0; reserve_en = 1'b0; reserve_addr = '0;
        step();
        step();
        rst_n = 1'b1;
        rd_addr_a = 4'd5; rd_addr_b = 4'd15;
        #1;
        chk("rst_rd_a", rd_data_a, 16'h0000);
        chk("rst_rd_b", rd_data_b, 16'h0000);
        chk("rst_busy_a", busy_a, 0);
        chk("rst_busy_b", busy_b, 0);
        chk("rst_ack", reg_ack, 0);
        write_en = 1'b1; write_addr = 4'd3; write_data = 16'hBEEF;
        chk("single_ack_before", reg_ack, 0);
        step();
        chk("single_ack_pulse", reg_ack, 1);
        step();
        chk("single_ack_fall", reg_ack, 0);
        write_en = 1'b0;
        rd_addr_a = 4'd3;
        #1;
        chk("single_rd3", rd_data_a, 16'hBEEF);
        step();
        chk("single_ack_idle", reg_ack, 0);
        write_en = 1'b1; write_addr = 4'd4; write_data = 16'hBEEF;
        acks = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (reg_ack) acks++;
            write_data = 16'h1234;
        end
        write_en = 1'b0;
        step();
        if (reg_ack) acks++;
        step();
        if (reg_ack) acks++;
        chk("long_ack_count", acks, 1);
        rd_addr_a = 4'd4;
        #1;
        chk("long_rd4", rd_data_a, 16'hBEEF);
        write_en = 1'b1; write_addr = 4'd0; write_data = 16'hFFFF;
        step();
        chk("r0_ack", reg_ack, 1);
        step();
        write_en = 1'b0;
        step();
        reserve_en = 1'b1; reserve_addr = 4'd0;
        step();
        reserve_en = 1'b0;
        rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        #1;
        chk("r0_rd", rd_data_a, 16'h0000);
        chk("r0_busy", busy_a, 0);
        chk("r0_busy_b", busy_b, 0);
        reserve_en = 1'b1; reserve_addr = 4'd7;
        rd_addr_a = 4'd7; rd_addr_b = 4'd7;
        #1;
        chk("sb_busy_before", busy_a, 0);
        step();
        reserve_en = 1'b0;
        chk("sb_busy_a", busy_a, 1);
        chk("sb_busy_b", busy_b, 1);
        write_en = 1'b1; write_addr = 4'd7; write_data = 16'h0042;
        step();
        chk("sb_clear_ack", reg_ack, 1);
        chk("sb_clear_busy", busy_a, 0);
        chk("sb_clear_rd", rd_data_a, 16'h0042);
        step();
        write_en = 1'b0;
        step();
        write_en = 1'b1; write_addr = 4'd7; write_data = 16'h0055;
        reserve_en = 1'b1; reserve_addr = 4'd7;
        step();
        reserve_en = 1'b0;
        chk("sb_same_ack", reg_ack, 1);
        chk("sb_same_busy", busy_a, 1);
        chk("sb_same_rd", rd_data_b, 16'h0055);
        step();
        write_en = 1'b0;
        step();
        wb_write(4'd1, 16'h0011, c1);
        wb_write(4'd2, 16'h0022, c2);
        wb_write(4'd1, 16'h0033, c3);
        chk("b2b_gap12", 32'(c2 - c1 >= 3), 1);
        chk("b2b_gap23", 32'(c3 - c2 >= 3), 1);
        rd_addr_a = 4'd1; rd_addr_b = 4'd2;
        #1;
        chk("b2b_r1", rd_data_a, 16'h0033);
        chk("b2b_r2", rd_data_b, 16'h0022);
        write_en = 1'b1; write_addr = 4'd2; write_data = 16'h0099;
        step();
        chk("rst_ack_state", reg_ack, 1);
        rst_n = 1'b0; write_en = 1'b0;
        step();
        rst_n = 1'b1;
        rd_addr_a = 4'd1; rd_addr_b = 4'd7;
        #1;
        chk("mid_rst_ack", reg_ack, 0);
        chk("mid_rst_r1", rd_data_a, 16'h0000);
        chk("mid_rst_busy7", busy_b, 0);
        rd_addr_a = 4'd2;
        #1;
        chk("mid_rst_r2", rd_data_a, 16'h0000);
        write_en = 1'b1; write_addr = 4'd5; write_data = 16'h00A5;
        step();
        chk("post_rst_ack", reg_ack, 1);
        step();
        write_en = 1'b0;
        step();
        rd_addr_a = 4'd5;
        #1;
        chk("post_rst_r5", rd_data_a, 16'h00A5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
